// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mux_rr_arbiter
// Brief   : 4-source round-robin arbiter with max-hold preemption driving a
//           registered 4:1 one-bit mux output.
// Revision: 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       z
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [3:0]        gnt_q,   gnt_d;
  logic [1:0]        sel_q,   sel_d;
  logic              busy_q,  busy_d;
  logic              z_q,     z_d;
  logic [HOLD_W-1:0] cnt_q,   cnt_d;
  logic [1:0]        ptr_q,   ptr_d;

  logic [1:0]        w_win;
  logic              w_release;

  // Scan from farthest to nearest so the closest requester after ptr wins.
  always_comb begin
    w_win = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        w_win = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    z_d     = busy_q ? din[sel_q] : 1'b0;

    w_release = !req[sel_q] || ((cnt_q == C_HOLD_LAST) && (|(req & ~gnt_q)));

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << w_win;
          sel_d   = w_win;
          busy_d  = 1'b1;
          ptr_d   = w_win;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end else if (cnt_q != C_HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ptr resets to 3 so that src0 is first in line after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      busy_q  <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign z    = z_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_rr_arbiter
// Brief   : Self-checking bench for mux_rr_arbiter against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int HOLD_W   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       z;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: owner is the granted source (-1 = none), held counts
  // cycles the current grant has been visible, prio is the last winner.
  int         owner;
  int         held;
  int         prio;
  logic [1:0] m_sel;
  logic       m_z;

  mux_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .z    (z)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    owner = -1;
    held  = 0;
    prio  = 3;
    m_sel = 2'd0;
    m_z   = 1'b0;
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    return {g, m_sel, (owner >= 0), m_z};
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic nz;
    bit   others;
    bit   found;
    int   w;
    if (rst) begin
      model_reset();
      return;
    end
    nz = (owner >= 0) ? din[m_sel] : 1'b0;
    if (owner < 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        w = (prio + k) % 4;
        if (!found && req[w]) begin
          found = 1;
          owner = w;
          m_sel = 2'(w);
          prio  = w;
          held  = 1;
        end
      end
    end else begin
      others = (req & ~(4'b0001 << owner)) != 4'b0000;
      if (!req[owner] || (held >= MAX_HOLD && others)) owner = -1;
      else held++;
    end
    m_z = nz;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; din = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({gnt, sel, busy, z} !== 8'h00) begin
      n_err++; $display("FAIL reset_init: got %b expected 00000000", {gnt, sel, busy, z});
    end
    rst = 1'b0;
    req = 4'b0010; din = 4'b0010;
    tick(); tick();
    n_vec++;
    if ({gnt, sel, busy, z} !== 8'b0010_01_1_1) begin
      n_err++; $display("FAIL pre_reset_grant: got %b expected 00100111", {gnt, sel, busy, z});
    end
    #2; rst = 1'b1; #1;
    model_reset();
    n_vec++;
    if ({gnt, sel, busy, z} !== 8'h00) begin
      n_err++; $display("FAIL async_reset: got %b expected 00000000", {gnt, sel, busy, z});
    end
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b1111;
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      n_err++; $display("FAIL post_reset_prio: got gnt=%b expected 0001", gnt);
    end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_single();
    req = 4'b0100; din = 4'b0100;
    tick();
    n_vec++;
    if ({gnt, sel, busy, z} !== 8'b0100_10_1_0) begin
      n_err++; $display("FAIL single_grant: got %b expected 01001010", {gnt, sel, busy, z});
    end
    tick();
    n_vec++;
    if (z !== 1'b1) begin
      n_err++; $display("FAIL single_z: got z=%b expected 1", z);
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    tick();
    n_vec++;
    if (z !== 1'b0) begin
      n_err++; $display("FAIL single_z_clear: got z=%b expected 0", z);
    end
  endtask

  task automatic test_full_load();
    int       prev_w;
    int       prev_t;
    int       w;
    logic     prev_busy;
    prev_w    = -1;
    prev_t    = 0;
    prev_busy = busy;
    req       = 4'b1111;
    for (int t = 0; t < 80; t++) begin
      din = 4'($urandom);
      tick();
      n_vec++;
      if ({gnt, sel, busy, z} !== model_out()) begin
        n_err++; $display("FAIL full_load[%0d]: got %b expected %b", t, {gnt, sel, busy, z}, model_out());
      end
      if (busy && !prev_busy) begin
        w = int'(sel);
        if (prev_w >= 0) begin
          n_vec++;
          if (w != (prev_w + 1) % 4 || t - prev_t != MAX_HOLD + 1) begin
            n_err++;
            $display("FAIL full_rotation: got src%0d after %0d cycles expected src%0d after %0d",
                     w, t - prev_t, (prev_w + 1) % 4, MAX_HOLD + 1);
          end
        end
        prev_w = w;
        prev_t = t;
      end
      prev_busy = busy;
    end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_solo_hold();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
        n_err++; $display("FAIL solo_hold[%0d]: got gnt=%b busy=%b expected 0001/1", i, gnt, busy);
      end
      din = 4'($urandom);
      tick();
    end
    req = 4'b0000;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL solo_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    tick();
  endtask

  task automatic test_fairness();
    req = 4'b0010;
    tick();
    n_vec++;
    if (gnt !== 4'b0010) begin
      n_err++; $display("FAIL fair_src1: got gnt=%b expected 0010", gnt);
    end
    req = 4'b0000; tick();
    req = 4'b1011; tick();
    n_vec++;
    if (gnt !== 4'b1000) begin
      n_err++; $display("FAIL fair_src3: got gnt=%b expected 1000", gnt);
    end
    req = 4'b0011; tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL fair_src3_release: got busy=%b expected 0", busy);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0001) begin
      n_err++; $display("FAIL fair_src0: got gnt=%b expected 0001", gnt);
    end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_coincident();
    req = 4'b1111;
    tick();
    n_vec++;
    if (gnt !== 4'b0010) begin
      n_err++; $display("FAIL coin_grant: got gnt=%b expected 0010", gnt);
    end
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      n_vec++;
      if (gnt !== 4'b0010 || busy !== 1'b1) begin
        n_err++; $display("FAIL coin_hold[%0d]: got gnt=%b busy=%b expected 0010/1", i, gnt, busy);
      end
    end
    req = 4'b1101;
    tick();
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL coin_release: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    tick();
    n_vec++;
    if (gnt !== 4'b0100) begin
      n_err++; $display("FAIL coin_next: got gnt=%b expected 0100", gnt);
    end
    req = 4'b0000; tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      din = 4'($urandom);
      if (rst) begin
        model_reset();
        #1;
        n_vec++;
        if ({gnt, sel, busy, z} !== 8'h00) begin
          n_err++; $display("FAIL rand_async_reset[%0d]: got %b expected 00000000", i, {gnt, sel, busy, z});
        end
      end
      tick();
      n_vec++;
      if ({gnt, sel, busy, z} !== model_out()) begin
        n_err++; $display("FAIL rand[%0d]: got %b expected %b", i, {gnt, sel, busy, z}, model_out());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_solo_hold();
    test_fairness();
    test_coincident();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
